// File: rtl/sram_sp_mask_ext.sv
// sram_sp_mask_ext
// Parametrised single-port SRAM model with segment write masks, a 1- or
// 2-cycle read pipeline, held read data with a one-cycle valid strobe, and a
// hardware clear sequencer that fills the array with INIT_VALUE after reset.
//
// Ports:
//   RW0_clk     in   sole clock, all state updates on its rising edge
//   RW0_reset   in   synchronous active-high reset
//   RW0_addr    in   word address (ADDR_W bits)
//   RW0_en      in   request enable
//   RW0_wmode   in   1 = write, 0 = read
//   RW0_wmask   in   per-segment write enables (MASK_SEG bits)
//   RW0_wdata   in   write data (WIDTH bits)
//   RW0_rdata   out  read data, held until the next read completes
//   RW0_rvalid  out  one-cycle strobe marking a fresh read result on rdata
//   RW0_ready   out  1 when requests are accepted (registered FSM state)
//
// Handshake: a request is accepted on any rising edge where RW0_ready = 1 and
// RW0_en = 1. There is no back-pressure once ready; requests presented while
// ready = 0 (reset or clear) are dropped, not stalled. Read results carry no
// ready of their own: RW0_rvalid pulses for exactly one cycle per accepted read.
module sram_sp_mask_ext #(
    parameter int              DEPTH          = 256,
    parameter int              WIDTH          = 8,
    parameter int              MASK_GRAN      = 1,
    parameter int              READ_LAT       = 1,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
    localparam int             MASK_SEG       = WIDTH / MASK_GRAN,
    localparam int             ADDR_W         = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic                RW0_clk,
    input  logic                RW0_reset,
    input  logic [ADDR_W-1:0]   RW0_addr,
    input  logic                RW0_en,
    input  logic                RW0_wmode,
    input  logic [MASK_SEG-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]    RW0_wdata,
    output logic [WIDTH-1:0]    RW0_rdata,
    output logic                RW0_rvalid,
    output logic                RW0_ready
);

    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("sram_sp_mask_ext: MASK_GRAN must divide WIDTH");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("sram_sp_mask_ext: READ_LAT must be 1 or 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_sp_mask_ext: DEPTH must be at least 2");
    end

    // DEPTH always fits in ADDR_W+1 bits, so range checks stay width-exact.
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;       // visible hierarchically for checkers
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;

    logic [WIDTH-1:0]  ram [DEPTH];

    logic              in_range;
    logic              accept;
    logic              do_write;
    logic              do_read;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  bit_mask;
    logic [WIDTH-1:0]  merged;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_last) begin
            state_next = ST_READY;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        RW0_ready = (state == ST_READY);
    end

    // Clear address counter; restarts from 0 on every reset.
    assign clr_last = (clr_cnt == LAST_ADR);

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
        end
    end

    // ---------------- request decode ----------------
    assign in_range = ({1'b0, RW0_addr} < DEPTH_W);
    assign accept   = (state == ST_READY) && RW0_en && !RW0_reset;
    assign do_write = accept && RW0_wmode && in_range;
    assign do_read  = accept && !RW0_wmode;

    // Out-of-range reads return zero; the index is never used in that case.
    assign rd_word = in_range ? ram[RW0_addr] : '0;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < MASK_SEG; i++) begin
            bit_mask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{RW0_wmask[i]}};
        end
    end

    // Read-modify-write merge: unmasked segments keep the stored value.
    assign merged = (rd_word & ~bit_mask) | (RW0_wdata & bit_mask);

    // ---------------- array (never reset) ----------------
    always_ff @(posedge RW0_clk) begin
        if (!RW0_reset && state == ST_CLEAR) begin
            ram[clr_cnt] <= INIT_VALUE;
        end else if (do_write) begin
            ram[RW0_addr] <= merged;
        end
    end

    // ---------------- read pipeline ----------------
    if (READ_LAT == 2) begin : g_lat2
        logic [WIDTH-1:0] s1_data;
        logic             s1_valid;

        always_ff @(posedge RW0_clk) begin
            if (RW0_reset) begin
                s1_data    <= '0;
                s1_valid   <= 1'b0;
                RW0_rdata  <= '0;
                RW0_rvalid <= 1'b0;
            end else begin
                s1_valid   <= do_read;
                if (do_read) begin
                    s1_data <= rd_word;
                end
                RW0_rvalid <= s1_valid;
                if (s1_valid) begin
                    RW0_rdata <= s1_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge RW0_clk) begin
            if (RW0_reset) begin
                RW0_rdata  <= '0;
                RW0_rvalid <= 1'b0;
            end else begin
                RW0_rvalid <= do_read;
                if (do_read) begin
                    RW0_rdata <= rd_word;
                end
            end
        end
    end

endmodule
